// File: rtl/me_pel_mem_pkg.sv
// Shared types and width helpers for the motion-estimation pel memory.
// Used by me_pel_mem, its interface and its RAM.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_TB = 2'd1,
    LOAD_SW = 2'd2,
    READY   = 2'd3
  } state_t;

  // Address width of a square block of the given side, matching the ME core.
  function automatic int addrWidth(input int side);
    return $clog2(side * side);
  endfunction

  function automatic int maxWidth(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/me_pel_mem_if.sv
// Host-load and ME-core read bus of me_pel_mem.
// The slave modport is the memory; the master modport is the host/ME side.
interface me_pel_mem_if
  import me_pkg::*;
#(
  parameter int TB_LENGTH = 16,
  parameter int SW_LENGTH = 64
);
  localparam int ADDR_TB = addrWidth(TB_LENGTH);
  localparam int ADDR_SW = addrWidth(SW_LENGTH);

  logic               i_ld_start;
  logic               i_ld_valid;
  logic               o_ld_ready;
  logic [7:0]         i_ld_data;
  logic               o_ready;
  logic               i_release;
  logic [ADDR_SW-1:0] i_addr_sw;
  logic [ADDR_TB-1:0] i_addr_tb;
  logic [7:0]         o_pel_sw;
  logic [7:0]         o_pel_tb;

  modport slave (
    input  i_ld_start, i_ld_valid, i_ld_data, i_release, i_addr_sw, i_addr_tb,
    output o_ld_ready, o_ready, o_pel_sw, o_pel_tb
  );

  modport master (
    output i_ld_start, i_ld_valid, i_ld_data, i_release, i_addr_sw, i_addr_tb,
    input  o_ld_ready, o_ready, o_pel_sw, o_pel_tb
  );

endinterface

// File: rtl/me_pel_mem_ram.sv
// Byte RAM with one write port and one registered read port.
// Read data is forced to zero whenever the read enable is low.
module me_pel_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_ren,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  localparam int DEPTH = 2 ** AW;

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_data;

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_data <= '0;
    else if (i_ren) r_data <= r_mem[i_raddr];
    else            r_data <= '0;
  end

  assign o_rdata = r_data;

endmodule

// File: rtl/me_pel_mem.sv
// Template-block / search-window pel memory loaded from a host byte stream.
// Define ME_PEL_DOUBLE_BUF_EN for front/back banks with background loading.
module me_pel_mem
  import me_pkg::*;
#(
  parameter int TB_LENGTH = 16,
  parameter int SW_LENGTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  me_pel_mem_if.slave bus
);
  localparam int ADDR_TB = addrWidth(TB_LENGTH);
  localparam int ADDR_SW = addrWidth(SW_LENGTH);
  localparam int CW      = maxWidth(ADDR_TB, ADDR_SW);
  localparam logic [CW-1:0] TB_LAST = CW'(TB_LENGTH * TB_LENGTH - 1);
  localparam logic [CW-1:0] SW_LAST = CW'(SW_LENGTH * SW_LENGTH - 1);

  state_t         r_state, w_nextState, w_phase, w_nextPhase;
  logic [CW-1:0]  r_count, w_nextCount;
  logic           r_ldReady, r_ready;
  logic           w_accept, w_done, w_tbWe, w_swWe, w_rdEn;
`ifdef ME_PEL_DOUBLE_BUF_EN
  state_t         r_bgPhase, w_nextBg;
  logic           r_backFull, w_nextFull, r_front, w_nextFront, r_rdBank, w_gap;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = bus.i_ld_valid & r_ldReady;
    w_done      = 1'b0;
    w_phase     = (r_state == LOAD_TB || r_state == LOAD_SW) ? r_state : IDLE;
`ifdef ME_PEL_DOUBLE_BUF_EN
    w_nextBg    = r_bgPhase;
    w_nextFull  = r_backFull;
    w_nextFront = r_front;
    w_gap       = 1'b0;
    if (r_state == READY) w_phase = r_bgPhase;
`endif
    w_nextPhase = w_phase;

    // Shared beat engine: serves the foreground load or the background one.
    if (w_accept) begin
      case (w_phase)
        LOAD_TB: begin
          if (r_count == TB_LAST) begin
            w_nextCount = '0;
            w_nextPhase = LOAD_SW;
          end else begin
            w_nextCount = r_count + 1'b1;
          end
        end
        LOAD_SW: begin
          if (r_count == SW_LAST) begin
            w_nextCount = '0;
            w_nextPhase = IDLE;
            w_done      = 1'b1;
          end else begin
            w_nextCount = r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (r_state)
      IDLE: begin
        if (bus.i_ld_start) begin
          w_nextState = LOAD_TB;
          w_nextCount = '0;
        end
      end
      LOAD_TB, LOAD_SW: begin
        w_nextState = w_done ? READY : w_nextPhase;
`ifdef ME_PEL_DOUBLE_BUF_EN
        if (w_done) w_nextFront = ~r_front;
`endif
      end
      READY: begin
`ifdef ME_PEL_DOUBLE_BUF_EN
        w_nextBg = w_nextPhase;
        if (w_done) w_nextFull = 1'b1;
        // Release wins over ld_start; a pending background load becomes foreground.
        if (bus.i_release) begin
          if (w_nextFull) begin
            w_nextFront = ~r_front;
            w_nextFull  = 1'b0;
            w_gap       = 1'b1;
          end else if (w_nextBg != IDLE) begin
            w_nextState = w_nextBg;
            w_nextBg    = IDLE;
          end else begin
            w_nextState = IDLE;
          end
        end else if (bus.i_ld_start && !r_backFull && r_bgPhase == IDLE) begin
          w_nextBg    = LOAD_TB;
          w_nextCount = '0;
        end
`else
        if (bus.i_release) w_nextState = IDLE;
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_ldReady <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
`ifdef ME_PEL_DOUBLE_BUF_EN
      r_ldReady <= (w_nextState == LOAD_TB) || (w_nextState == LOAD_SW) || (w_nextBg != IDLE);
      r_ready   <= (w_nextState == READY) && !w_gap;
`else
      r_ldReady <= (w_nextState == LOAD_TB) || (w_nextState == LOAD_SW);
      r_ready   <= (w_nextState == READY);
`endif
    end
  end

  assign w_tbWe = w_accept && (w_phase == LOAD_TB);
  assign w_swWe = w_accept && (w_phase == LOAD_SW);
  assign w_rdEn = (r_state == READY);

  assign bus.o_ld_ready = r_ldReady;
  assign bus.o_ready    = r_ready;

`ifdef ME_PEL_DOUBLE_BUF_EN
  logic [7:0] w_tbData [2];
  logic [7:0] w_swData [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bgPhase  <= IDLE;
      r_backFull <= 1'b0;
      r_front    <= 1'b0;
      r_rdBank   <= 1'b0;
    end else begin
      r_bgPhase  <= w_nextBg;
      r_backFull <= w_nextFull;
      r_front    <= w_nextFront;
      r_rdBank   <= r_front;
    end
  end

  // Loads always target the non-front bank; r_rdBank tracks the bank of the data in flight.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    me_pel_ram #(.AW(ADDR_TB)) u_tb (
      .clk(clk), .rst(rst),
      .i_we(w_tbWe && (r_front != 1'(b))), .i_waddr(r_count[ADDR_TB-1:0]), .i_wdata(bus.i_ld_data),
      .i_ren(w_rdEn), .i_raddr(bus.i_addr_tb), .o_rdata(w_tbData[b])
    );
    me_pel_ram #(.AW(ADDR_SW)) u_sw (
      .clk(clk), .rst(rst),
      .i_we(w_swWe && (r_front != 1'(b))), .i_waddr(r_count[ADDR_SW-1:0]), .i_wdata(bus.i_ld_data),
      .i_ren(w_rdEn), .i_raddr(bus.i_addr_sw), .o_rdata(w_swData[b])
    );
  end

  assign bus.o_pel_tb = w_tbData[r_rdBank];
  assign bus.o_pel_sw = w_swData[r_rdBank];
`else
  me_pel_ram #(.AW(ADDR_TB)) u_tb (
    .clk(clk), .rst(rst),
    .i_we(w_tbWe), .i_waddr(r_count[ADDR_TB-1:0]), .i_wdata(bus.i_ld_data),
    .i_ren(w_rdEn), .i_raddr(bus.i_addr_tb), .o_rdata(bus.o_pel_tb)
  );
  me_pel_ram #(.AW(ADDR_SW)) u_sw (
    .clk(clk), .rst(rst),
    .i_we(w_swWe), .i_waddr(r_count[ADDR_SW-1:0]), .i_wdata(bus.i_ld_data),
    .i_ren(w_rdEn), .i_raddr(bus.i_addr_sw), .o_rdata(bus.o_pel_sw)
  );
`endif

endmodule

// File: tb/tb_me_pel_mem.sv
// Scoreboard bench for me_pel_mem: loads keyed images and checks read-back.
// Extra background-load checks are built when ME_PEL_DOUBLE_BUF_EN is defined.
module tb_me_pel_mem;
  localparam int TB_LENGTH = 16;
  localparam int SW_LENGTH = 64;
  localparam int TB_BEATS  = TB_LENGTH * TB_LENGTH;
  localparam int SW_BEATS  = SW_LENGTH * SW_LENGTH;
  localparam int TOTAL     = TB_BEATS + SW_BEATS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_pel_mem_if #(.TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH)) bus ();

  me_pel_mem #(.TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] qTb [$];
  logic [7:0] qSw [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each RAM holds its own index (low byte) XOR a per-image key.
  function automatic logic [7:0] pelPattern(input int idx, input logic [7:0] key);
    return idx[7:0] ^ key;
  endfunction

  // Pulses ld_start, then streams beats until 'beats' are accepted; returns at the
  // falling edge on which the last beat is presented.
  task automatic applyStimulus(input logic [7:0] key, input bit toggle, input bit poke,
                               input int beats, output int n);
    int  cyc;
    bit  rdy;
    n   = 0;
    cyc = 0;
    @(negedge clk);
    bus.i_ld_start = 1'b1;
    @(negedge clk);
    bus.i_ld_start = 1'b0;
    while (n < beats && cyc < 4 * TOTAL) begin
      rdy              = bus.o_ld_ready;
      bus.i_ld_valid   = toggle ? ~cyc[0] : 1'b1;
      bus.i_ld_data    = pelPattern((n < TB_BEATS) ? n : n - TB_BEATS, key);
      bus.i_ld_start   = poke && (n == 100);
      bus.i_release    = poke && (n == 1000);
      if (bus.i_ld_valid && rdy) n++;
      cyc++;
      if (n < beats) @(negedge clk);
    end
    bus.i_ld_start = 1'b0;
    bus.i_release  = 1'b0;
  endtask

  task automatic fullLoad(input logic [7:0] key, input bit toggle, input bit poke, input bit readyDuring);
    int n;
    applyStimulus(key, toggle, poke, TOTAL, n);
    checkOutput("beatCount", n, TOTAL);
    checkOutput("readyBeforeLast", {31'd0, bus.o_ready}, {31'd0, readyDuring});
    @(negedge clk);
    bus.i_ld_valid = 1'b0;
    checkOutput("readyAfterLast", {31'd0, bus.o_ready}, 32'd1);
    checkOutput("ldReadyAfterLast", {31'd0, bus.o_ld_ready}, 32'd0);
  endtask

  // Drives one address pair per cycle and checks the data one cycle later.
  task automatic readBurst(input logic [7:0] key, input int count);
    logic [7:0]  atb;
    logic [11:0] asw;
    for (int i = 0; i <= count; i++) begin
      @(negedge clk);
      if (qTb.size() > 0) begin
        checkOutput("pelTb", {24'd0, bus.o_pel_tb}, {24'd0, qTb.pop_front()});
        checkOutput("pelSw", {24'd0, bus.o_pel_sw}, {24'd0, qSw.pop_front()});
      end
      if (i < count) begin
        atb = (i == 0) ? 8'h25 : 8'($urandom_range(0, TB_BEATS - 1));
        asw = (i == 0) ? 12'hABC : 12'($urandom_range(0, SW_BEATS - 1));
        bus.i_addr_tb = atb;
        bus.i_addr_sw = asw;
        qTb.push_back(pelPattern(int'(atb), key));
        qSw.push_back(pelPattern(int'(asw), key));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.i_ld_start = 1'b0;
    bus.i_ld_valid = 1'b0;
    bus.i_ld_data  = '0;
    bus.i_release  = 1'b0;
    bus.i_addr_tb  = '0;
    bus.i_addr_sw  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetLdReady", {31'd0, bus.o_ld_ready}, 32'd0);
    checkOutput("resetReady",   {31'd0, bus.o_ready},    32'd0);
    checkOutput("resetPelTb",   {24'd0, bus.o_pel_tb},   32'd0);
    checkOutput("resetPelSw",   {24'd0, bus.o_pel_sw},   32'd0);
    rst = 1'b0;

    $display("[TB] reset in the middle of the SW load");
    applyStimulus(8'h11, 1'b0, 1'b0, TB_BEATS + 100, n);
    checkOutput("midBeats", n, TB_BEATS + 100);
    rst = 1'b1;
    #1;
    checkOutput("midRstLdReady", {31'd0, bus.o_ld_ready}, 32'd0);
    checkOutput("midRstReady",   {31'd0, bus.o_ready},    32'd0);
    checkOutput("midRstPelTb",   {24'd0, bus.o_pel_tb},   32'd0);
    checkOutput("midRstPelSw",   {24'd0, bus.o_pel_sw},   32'd0);
    @(negedge clk);
    bus.i_ld_valid = 1'b0;
    rst = 1'b0;

    $display("[TB] full load with stray ld_start/release, then reads");
    fullLoad(8'h00, 1'b0, 1'b1, 1'b0);
    readBurst(8'h00, 24);

    $display("[TB] release and ld_start together in READY");
    @(negedge clk);
    bus.i_release  = 1'b1;
    bus.i_ld_start = 1'b1;
    @(negedge clk);
    bus.i_release  = 1'b0;
    bus.i_ld_start = 1'b0;
    checkOutput("relStartReady",   {31'd0, bus.o_ready},    32'd0);
    checkOutput("relStartLdReady", {31'd0, bus.o_ld_ready}, 32'd0);
    @(negedge clk);
    checkOutput("relStartLdReady2", {31'd0, bus.o_ld_ready}, 32'd0);
    checkOutput("idlePelTb",        {24'd0, bus.o_pel_tb},   32'd0);

    $display("[TB] load with ld_valid toggling");
    fullLoad(8'h5A, 1'b1, 1'b0, 1'b0);
    readBurst(8'h5A, 24);

`ifdef ME_PEL_DOUBLE_BUF_EN
    $display("[TB] background load while reading the front bank");
    fork
      fullLoad(8'hC3, 1'b0, 1'b0, 1'b1);
      readBurst(8'h5A, 60);
    join
    @(negedge clk);
    bus.i_release = 1'b1;
    @(negedge clk);
    bus.i_release = 1'b0;
    checkOutput("swapReadyLow", {31'd0, bus.o_ready}, 32'd0);
    @(negedge clk);
    checkOutput("swapReadyHigh", {31'd0, bus.o_ready}, 32'd1);
    readBurst(8'hC3, 24);
    @(negedge clk);
    bus.i_release = 1'b1;
    @(negedge clk);
    bus.i_release = 1'b0;
    checkOutput("finalRelReady",   {31'd0, bus.o_ready},    32'd0);
    checkOutput("finalRelLdReady", {31'd0, bus.o_ld_ready}, 32'd0);
    @(negedge clk);
    checkOutput("finalIdleReady", {31'd0, bus.o_ready},  32'd0);
    checkOutput("finalIdlePelSw", {24'd0, bus.o_pel_sw}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
